// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the two-source Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned GAP_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    typedef logic src_idx_t;

    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

endpackage

// File: rtl/eth_tx_arb_rr.sv
// Two-input round-robin grant decision; purely combinational.
module eth_tx_arb_rr
    import eth_tx_arb_pkg::*;
(
    input  logic     valid0_i,
    input  logic     valid1_i,
    input  src_idx_t last_grant_i,
    output logic     req_o,
    output src_idx_t grant_o
);

    // A lone requester wins; on a tie the source that did not win last time wins.
    always_comb begin
        req_o   = valid0_i | valid1_i;
        grant_o = last_grant_i;
        if (valid0_i && !valid1_i) begin
            grant_o = 1'b0;
        end else if (!valid0_i && valid1_i) begin
            grant_o = 1'b1;
        end else if (valid0_i && valid1_i) begin
            grant_o = ~last_grant_i;
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the tx_mac AXI-Stream input
// between two sources, with per-source completed-frame counters.
// Optional inter-frame gap state is built when ETH_TX_ARB_IFG_EN is defined.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tuser,
    output logic                  s0_axis_trdy,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tuser,
    output logic                  s1_axis_trdy,

    output logic [DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic                  m_tx_axis_tvalid,
    output logic                  m_tx_axis_tlast,
    output logic                  m_tx_axis_tuser,
    input  logic                  m_tx_axis_trdy,

    output logic [1:0]            grant,
    output logic [FRAME_CNT_W-1:0] frame_cnt0,
    output logic [FRAME_CNT_W-1:0] frame_cnt1
);

    // Parameter range check at elaboration.
    if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_ifg_range
        $error("IFG_CYCLES must be in 1..255");
    end

    arb_state_t state_q, state_d;
    src_idx_t   last_grant_q, last_grant_d;
    frame_cnt_t cnt0_q, cnt0_d;
    frame_cnt_t cnt1_q, cnt1_d;
    logic       frame_done;
    logic       rr_req;
    src_idx_t   rr_grant;

`ifdef ETH_TX_ARB_IFG_EN
    localparam logic [GAP_CNT_W-1:0] IFG_LOAD = GAP_CNT_W'(IFG_CYCLES);
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    eth_tx_arb_rr u_rr (
        .valid0_i     (s0_axis_tvalid),
        .valid1_i     (s1_axis_tvalid),
        .last_grant_i (last_grant_q),
        .req_o        (rr_req),
        .grant_o      (rr_grant)
    );

    // Next-state, counter and datapath-mux decode; the mux stays combinational.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        cnt0_d           = cnt0_q;
        cnt1_d           = cnt1_q;
        frame_done       = 1'b0;
        grant            = 2'b00;
        m_tx_axis_tdata  = '0;
        m_tx_axis_tvalid = 1'b0;
        m_tx_axis_tlast  = 1'b0;
        m_tx_axis_tuser  = 1'b0;
        s0_axis_trdy     = 1'b0;
        s1_axis_trdy     = 1'b0;
`ifdef ETH_TX_ARB_IFG_EN
        gap_cnt_d        = gap_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (rr_req) begin
                    last_grant_d = rr_grant;
                    state_d      = rr_grant ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                grant            = 2'b01;
                m_tx_axis_tdata  = s0_axis_tdata;
                m_tx_axis_tvalid = s0_axis_tvalid;
                m_tx_axis_tlast  = s0_axis_tlast;
                m_tx_axis_tuser  = s0_axis_tuser;
                s0_axis_trdy     = m_tx_axis_trdy;
                if (s0_axis_tvalid && m_tx_axis_trdy && s0_axis_tlast) begin
                    cnt0_d     = cnt0_q + FRAME_CNT_W'(1);
                    frame_done = 1'b1;
                end
            end
            GRANT1: begin
                grant            = 2'b10;
                m_tx_axis_tdata  = s1_axis_tdata;
                m_tx_axis_tvalid = s1_axis_tvalid;
                m_tx_axis_tlast  = s1_axis_tlast;
                m_tx_axis_tuser  = s1_axis_tuser;
                s1_axis_trdy     = m_tx_axis_trdy;
                if (s1_axis_tvalid && m_tx_axis_trdy && s1_axis_tlast) begin
                    cnt1_d     = cnt1_q + FRAME_CNT_W'(1);
                    frame_done = 1'b1;
                end
            end
`ifdef ETH_TX_ARB_IFG_EN
            GAP: begin
                if (gap_cnt_q <= GAP_CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_done) begin
`ifdef ETH_TX_ARB_IFG_EN
            state_d   = GAP;
            gap_cnt_d = IFG_LOAD;
`else
            state_d   = IDLE;
`endif
        end
    end

    // State, last-grant and frame counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

`ifdef ETH_TX_ARB_IFG_EN
    // Inter-frame gap down-counter, loaded on the tlast handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    assign frame_cnt0 = cnt0_q;
    assign frame_cnt1 = cnt1_q;

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-level round-robin arbiter that shares the single TX MAC AXI-Stream input between two frame sources, e.g. the UDP/IP packet path and the ARP responder. A grant is held from the first beat to the `tlast` handshake, so frames are never interleaved. It sits directly upstream of `tx_mac`, in the same `clk` domain as `rx_mac`, and also counts completed frames per source.

## Interface
- `DATA_WIDTH`, 8: AXI-Stream data width, matching `tx_mac`.
- `IFG_CYCLES`, 12: idle cycles forced after each frame; used only when `ETH_TX_ARB_IFG_EN` is defined; legal range 1..255.

Ports:
- `clk` in 1: system clock; one clock domain for the whole block.
- `reset` in 1: asynchronous, active-high reset.
- `s0_axis_tdata` in DATA_WIDTH: source 0 data.
- `s0_axis_tvalid` in 1: source 0 valid.
- `s0_axis_tlast` in 1: source 0 end of frame.
- `s0_axis_tuser` in 1: source 0 error/abort flag, passed through unchanged.
- `s0_axis_trdy` out 1: ready to source 0.
- `s1_axis_tdata`, `s1_axis_tvalid`, `s1_axis_tlast`, `s1_axis_tuser`, `s1_axis_trdy`: same as source 0, for source 1.
- `m_tx_axis_tdata` out DATA_WIDTH: data to `tx_mac`.
- `m_tx_axis_tvalid` out 1: valid to `tx_mac`.
- `m_tx_axis_tlast` out 1: end of frame to `tx_mac`.
- `m_tx_axis_tuser` out 1: error flag to `tx_mac`.
- `m_tx_axis_trdy` in 1: ready from `tx_mac`.
- `grant` out 2: one-hot active source; 2'b00 when no source holds a grant.
- `frame_cnt0` out 16: frames completed by source 0; wraps from 0xFFFF to 0.
- `frame_cnt1` out 16: frames completed by source 1; wraps from 0xFFFF to 0.

## Operation
- States are IDLE, GRANT0, GRANT1 and, when the macro is defined, GAP.
- IDLE:
  - Only `s0_axis_tvalid` high: go to GRANT0.
  - Only `s1_axis_tvalid` high: go to GRANT1.
  - Both high: grant the source that is not `last_grant`.
  - Neither high: stay in IDLE.
- `last_grant` is a register that updates on every grant. Its reset value is 1, so source 0 wins the first tie.
- GRANTn datapath: `m_tx_axis_{tdata,tvalid,tlast,tuser}` are a combinational mux of source n, and `sn_axis_trdy` = `m_tx_axis_trdy`.
- The non-granted source's `trdy` is 0 in every state. `m_tx_axis_tvalid` is 0 outside GRANTn.
- Frame end: a `tvalid && trdy && tlast` beat in GRANTn:
  - increments `frame_cnt{n}`;
  - moves the FSM to IDLE, or to GAP when the macro is defined.
- A source that drops `tvalid` mid-frame keeps its grant, and the output shows a bubble. The arbiter never times out.
- A single-beat frame (`tlast` on the first beat) is legal and counts as one frame.
- `tuser` is not interpreted; an aborted frame is counted like any other frame.

## Timing
- Reset values: FSM in IDLE, `grant` = 0, `last_grant` = 1, both counters 0, all `tvalid` and `trdy` outputs 0.
- Reset is asynchronous and can assert mid-frame. The grant drops immediately and the downstream sees a truncated frame. Sources must restart their frames; the arbiter performs no recovery.
- Arbitration latency: `tvalid` is sampled in IDLE on edge k. `grant` and the mux are valid after edge k, so the first beat can be accepted on edge k+1.
- Back-to-back frames: at least one IDLE cycle separates frames when the macro is not defined.
- The counter increment and the state change take effect on the same edge as the `tlast` handshake.
- There are no registers in the data path. Combinational paths are only `m_tx_axis_trdy` to `sn_axis_trdy` and `sn` to `m_tx_axis_*`.

## Configuration
- `ETH_TX_ARB_IFG_EN` defined:
  - After each frame, GAP holds for exactly `IFG_CYCLES` cycles with both `trdy` = 0 and `m_tx_axis_tvalid` = 0, then returns to IDLE.
  - An 8-bit down-counter loads on the `tlast` edge.
- `ETH_TX_ARB_IFG_EN` undefined: GAP and its counter are not built, and `IFG_CYCLES` is ignored.

## Structure
- Shared package `eth_tx_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, GRANT0, GRANT1, GAP);
  - `src_idx_t` (1-bit);
  - localparam `FRAME_CNT_W` = 16.
- Sub-module `eth_tx_arb_rr` is the two-input round-robin grant decision. It is purely combinational: inputs are both `tvalid` signals and `last_grant`; output is the next grant.

## Test plan
- Only s0 sends a 64-byte frame with `m_tx_axis_trdy` held at 1. Expected: `grant` = 01 one cycle after `tvalid`; 64 beats out identical to the input; `frame_cnt0` = 1; `frame_cnt1` = 0.
- Both sources hold 3 frames each, continuously valid. Expected output order s0, s1, s0, s1, s0, s1 with no interleaved beats; both counters end at 3.
- `m_tx_axis_trdy` toggles randomly and s1 inserts `tvalid` gaps mid-frame. Expected: no beat lost or duplicated, s0 `trdy` stays 0 throughout, and the grant is held until `tlast`.
- Preload `frame_cnt0` to 0xFFFF via 65535 single-beat frames (or force), then send 1 more frame. Expected: `frame_cnt0` = 0.
- Assert `reset` during beat 10 of an s1 frame. Expected: in the same cycle `grant` = 0, `m_tx_axis_tvalid` = 0, both `trdy` = 0 and counters = 0; after release, s0 wins the first tie.
- With `ETH_TX_ARB_IFG_EN` defined and `IFG_CYCLES` = 12, send two queued frames. Expected: exactly 12 cycles of GAP plus 1 IDLE cycle between the `tlast` beat and the next first beat.
